// File: rtl/fpu_mul_core_if.sv
// Handshake and operand/result bundle between the FPU arithmetic controller
// and the sequential single-precision multiplier.
interface fpu_mul_core_if;
    logic        start_i;
    logic        ack_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        busy_o;
    logic        overflow_o;
    logic        underflow_o;

    modport master (
        output start_i, ack_i, a_i, b_i,
        input  result_o, result_valid_o, busy_o, overflow_o, underflow_o
    );

    modport slave (
        input  start_i, ack_i, a_i, b_i,
        output result_o, result_valid_o, busy_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/fpu_mul_core.sv
// Sequential IEEE-754 single-precision multiplier using a 24-iteration shift-add
// mantissa product. Define FPU_MUL_RNE_EN for round-to-nearest-even (default: truncate).
module fpu_mul_core #(
    parameter int MANT_W   = 24,
    parameter int EXP_BIAS = 127
) (
    input  logic           clk,
    input  logic           arst,
    fpu_mul_core_if.slave  bus
);
    typedef enum logic [2:0] {
        mul_idle_st,
        mul_start_st,
        mul_product_add_st,
        mul_product_shift_st,
        mul_result_set_st,
        mul_result_valid_st
    } e_mul_states;

    e_mul_states           state_reg;
    logic [31:0]           a_reg;
    logic [31:0]           b_reg;
    logic [2*MANT_W:0]     prod_reg;
    logic [MANT_W-1:0]     ma_reg;
    logic [MANT_W-1:0]     mplier_reg;
    logic [4:0]            count_reg;
    logic                  sign_reg;
    logic signed [9:0]     exp_reg;
    logic                  special_reg;
    logic [31:0]           special_res_reg;
    logic [31:0]           result_reg;
    logic                  valid_reg;
    logic                  busy_reg;
    logic                  ovf_reg;
    logic                  unf_reg;

    // Operand classification; denormals (exp == 0) count as zero.
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        sign_in;
    logic [9:0]  exp_sum;

    always_comb begin
        ea      = a_reg[30:23];
        eb      = b_reg[30:23];
        fa      = a_reg[22:0];
        fb      = b_reg[22:0];
        a_zero  = (ea == 8'd0);
        b_zero  = (eb == 8'd0);
        a_inf   = (ea == 8'hFF) && (fa == 23'd0);
        b_inf   = (eb == 8'hFF) && (fb == 23'd0);
        a_nan   = (ea == 8'hFF) && (fa != 23'd0);
        b_nan   = (eb == 8'hFF) && (fb != 23'd0);
        sign_in = a_reg[31] ^ b_reg[31];
        exp_sum = {2'b00, ea} + {2'b00, eb} - 10'(EXP_BIAS);
    end

    // Normalise, optionally round, then saturate/flush the packed result.
    logic [22:0]       mant_norm, mant_final;
    logic signed [9:0] exp_norm, exp_final;
    logic [31:0]       res_next;
    logic              ovf_next, unf_next;
`ifdef FPU_MUL_RNE_EN
    logic              guard, sticky;
    logic [23:0]       mant_inc;
`endif

    always_comb begin
        if (prod_reg[47]) begin
            exp_norm  = exp_reg + 10'sd1;
            mant_norm = prod_reg[46:24];
        end else begin
            exp_norm  = exp_reg;
            mant_norm = prod_reg[45:23];
        end
        mant_final = mant_norm;
        exp_final  = exp_norm;
`ifdef FPU_MUL_RNE_EN
        guard    = prod_reg[47] ? prod_reg[23] : prod_reg[22];
        sticky   = prod_reg[47] ? (|prod_reg[22:0]) : (|prod_reg[21:0]);
        mant_inc = {1'b0, mant_norm} + 24'd1;
        if (guard && (sticky || mant_norm[0])) begin
            mant_final = mant_inc[22:0];
            if (mant_inc[23]) begin
                exp_final = exp_norm + 10'sd1;
            end
        end
`endif
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (special_reg) begin
            res_next = special_res_reg;
        end else if (exp_final >= 10'sd255) begin
            res_next = {sign_reg, 8'hFF, 23'd0};
            ovf_next = 1'b1;
        end else if (exp_final <= 10'sd0) begin
            res_next = {sign_reg, 31'd0};
            unf_next = 1'b1;
        end else begin
            res_next = {sign_reg, exp_final[7:0], mant_final};
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_reg       <= mul_idle_st;
            a_reg           <= '0;
            b_reg           <= '0;
            prod_reg        <= '0;
            ma_reg          <= '0;
            mplier_reg      <= '0;
            count_reg       <= '0;
            sign_reg        <= 1'b0;
            exp_reg         <= '0;
            special_reg     <= 1'b0;
            special_res_reg <= '0;
            result_reg      <= '0;
            valid_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            ovf_reg         <= 1'b0;
            unf_reg         <= 1'b0;
        end else begin
            case (state_reg)
                mul_idle_st: begin
                    if (bus.start_i) begin
                        a_reg     <= bus.a_i;
                        b_reg     <= bus.b_i;
                        busy_reg  <= 1'b1;
                        state_reg <= mul_start_st;
                    end
                end
                mul_start_st: begin
                    sign_reg <= sign_in;
                    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
                        special_reg     <= 1'b1;
                        special_res_reg <= 32'h7FC0_0000;
                        state_reg       <= mul_result_set_st;
                    end else if (a_inf || b_inf) begin
                        special_reg     <= 1'b1;
                        special_res_reg <= {sign_in, 8'hFF, 23'd0};
                        state_reg       <= mul_result_set_st;
                    end else if (a_zero || b_zero) begin
                        special_reg     <= 1'b1;
                        special_res_reg <= {sign_in, 31'd0};
                        state_reg       <= mul_result_set_st;
                    end else begin
                        special_reg <= 1'b0;
                        prod_reg    <= '0;
                        ma_reg      <= {1'b1, fa};
                        mplier_reg  <= {1'b1, fb};
                        count_reg   <= '0;
                        exp_reg     <= exp_sum;
                        state_reg   <= mul_product_add_st;
                    end
                end
                mul_product_add_st: begin
                    if (mplier_reg[0]) begin
                        prod_reg[2*MANT_W:MANT_W] <= prod_reg[2*MANT_W:MANT_W] + {1'b0, ma_reg};
                    end
                    state_reg <= mul_product_shift_st;
                end
                mul_product_shift_st: begin
                    prod_reg   <= prod_reg >> 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + 5'd1;
                    state_reg  <= (count_reg == 5'(MANT_W - 1)) ? mul_result_set_st
                                                                : mul_product_add_st;
                end
                mul_result_set_st: begin
                    result_reg <= res_next;
                    ovf_reg    <= ovf_next;
                    unf_reg    <= unf_next;
                    valid_reg  <= 1'b1;
                    state_reg  <= mul_result_valid_st;
                end
                mul_result_valid_st: begin
                    if (bus.ack_i) begin
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= mul_idle_st;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= mul_idle_st;
                end
            endcase
        end
    end

    assign bus.result_o       = result_reg;
    assign bus.result_valid_o = valid_reg;
    assign bus.busy_o         = busy_reg;
    assign bus.overflow_o     = ovf_reg;
    assign bus.underflow_o    = unf_reg;
endmodule
